// File: rtl/flag_checker_pkg.sv
// flag_pkg: shared FSM state, flag bundle and block-count helper for flag_checker
// Contents:
//   state_t   - checker FSM state (IDLE between images, RUN inside an image)
//   flags_t   - the four end-of-unit flags carried with each beat
//   blocks_m1 - number of blocks along one image dimension, minus one,
//               from minus-one encoded image and block sizes
package flag_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      logic last_s;
      logic last_r;
      logic last_b;
      logic last_i;
   } flags_t;

   function automatic logic [31:0] blocks_m1(input logic [31:0] img_m1, input logic [31:0] blk_m1);
      return (img_m1 + 32'd1) / (blk_m1 + 32'd1) - 32'd1;
   endfunction

endpackage

// File: rtl/flag_checker_if.sv
// flag_checker_if: input and output beat streams of flag_checker
// Signals:
//   input_data/input_valid/input_ready        - incoming sample stream
//   input_last_s/_r/_b/_i                     - flags received with each sample
//   output_data/output_valid/output_ready     - registered pass-through stream
//   output_last                               - expected end of image for the output beat
// Modports:
//   master - the stream source and sink (testbench or surrounding logic)
//   slave  - the checker itself
interface flag_checker_if #(
   parameter int DATA_WIDTH = 16
);

   logic [DATA_WIDTH-1:0] input_data;
   logic                  input_valid;
   logic                  input_ready;
   logic                  input_last_s;
   logic                  input_last_r;
   logic                  input_last_b;
   logic                  input_last_i;
   logic [DATA_WIDTH-1:0] output_data;
   logic                  output_valid;
   logic                  output_ready;
   logic                  output_last;

   modport master (
      output input_data, input_valid, input_last_s, input_last_r, input_last_b, input_last_i,
      output output_ready,
      input  input_ready, output_data, output_valid, output_last
   );

   modport slave (
      input  input_data, input_valid, input_last_s, input_last_r, input_last_b, input_last_i,
      input  output_ready,
      output input_ready, output_data, output_valid, output_last
   );

endinterface

// File: rtl/flag_checker_wrap_counter.sv
// wrap_counter: enabled up-counter that wraps to zero after reaching a terminal value
// Ports:
//   clk, rst     - clock and asynchronous active-high reset (count returns to 0)
//   en_i         - advance the count this cycle
//   term_val_i   - last value before wrapping
//   term_o       - count currently equals term_val_i
module wrap_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] term_val_i,
   output logic             term_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign term_o = cnt_q == term_val_i;

   always_comb begin
      cnt_d = en_i ? (term_o ? '0 : cnt_q + WIDTH'(1)) : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/flag_checker.sv
// flag_checker: checks received block/image flags against a locally tracked traversal
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   config_block_samples     - block width minus one
//   config_block_lines       - block height minus one
//   config_image_samples     - image width minus one
//   config_image_lines       - image height minus one
//   config_image_bands       - band count minus one
//   bus (slave)              - input stream with received flags, registered output stream
//   error_flag               - sticky: some accepted beat carried a wrong flag
//   error_count              - saturating count of beats with wrong flags
//   image_done               - one-cycle pulse after the final beat of an image
module flag_checker
   import flag_pkg::*;
#(
   parameter int DATA_WIDTH           = 16,
   parameter int MAX_BLOCK_SAMPLE_LOG = 4,
   parameter int MAX_BLOCK_LINE_LOG   = 4,
   parameter int MAX_IMAGE_SAMPLE_LOG = 12,
   parameter int MAX_IMAGE_LINE_LOG   = 12,
   parameter int MAX_IMAGE_BAND_LOG   = 12,
   parameter int ERR_COUNT_WIDTH      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [MAX_BLOCK_SAMPLE_LOG-1:0] config_block_samples,
   input  logic [MAX_BLOCK_LINE_LOG-1:0]   config_block_lines,
   input  logic [MAX_IMAGE_SAMPLE_LOG-1:0] config_image_samples,
   input  logic [MAX_IMAGE_LINE_LOG-1:0]   config_image_lines,
   input  logic [MAX_IMAGE_BAND_LOG-1:0]   config_image_bands,
   flag_checker_if.slave                   bus,
   output logic                            error_flag,
   output logic [ERR_COUNT_WIDTH-1:0]      error_count,
   output logic                            image_done
);

   state_t state_q, state_d;

   logic [MAX_BLOCK_SAMPLE_LOG-1:0] cfg_bs_q, cfg_bs_d, bs;
   logic [MAX_BLOCK_LINE_LOG-1:0]   cfg_bl_q, cfg_bl_d, bl;
   logic [MAX_IMAGE_SAMPLE_LOG-1:0] cfg_is_q, cfg_is_d, is, col_last;
   logic [MAX_IMAGE_LINE_LOG-1:0]   cfg_il_q, cfg_il_d, il, row_last;
   logic [MAX_IMAGE_BAND_LOG-1:0]   cfg_nb_q, cfg_nb_d, nb;

   logic                       rdy_q;
   logic                       ov_q, ov_d, ol_q, ol_d;
   logic [DATA_WIDTH-1:0]      od_q, od_d;
   logic                       ef_q, ef_d, done_q, done_d;
   logic [ERR_COUNT_WIDTH-1:0] ec_q, ec_d;

   logic   in_rdy, acc, first, mism;
   logic   smp_t, line_t, band_t, col_t, row_t;
   flags_t exp_f, rcv_f;

   // The first beat of an image already needs the new geometry, so the live
   // config is used while idle and the latched copy for the rest of the image.
   assign first = state_q == IDLE;
   assign bs    = first ? config_block_samples : cfg_bs_q;
   assign bl    = first ? config_block_lines   : cfg_bl_q;
   assign is    = first ? config_image_samples : cfg_is_q;
   assign il    = first ? config_image_lines   : cfg_il_q;
   assign nb    = first ? config_image_bands   : cfg_nb_q;

   assign col_last = MAX_IMAGE_SAMPLE_LOG'(blocks_m1(32'(is), 32'(bs)));
   assign row_last = MAX_IMAGE_LINE_LOG'(blocks_m1(32'(il), 32'(bl)));

   // rdy_q keeps input_ready low through reset until the first clock edge after it.
   assign in_rdy = rdy_q & (~ov_q | bus.output_ready);
   assign acc    = bus.input_valid & in_rdy;

   wrap_counter #(.WIDTH(MAX_BLOCK_SAMPLE_LOG)) u_sample (
      .clk, .rst, .en_i(acc), .term_val_i(bs), .term_o(smp_t)
   );
   wrap_counter #(.WIDTH(MAX_BLOCK_LINE_LOG)) u_line (
      .clk, .rst, .en_i(acc & smp_t), .term_val_i(bl), .term_o(line_t)
   );
   wrap_counter #(.WIDTH(MAX_IMAGE_BAND_LOG)) u_band (
      .clk, .rst, .en_i(acc & smp_t & line_t), .term_val_i(nb), .term_o(band_t)
   );
   wrap_counter #(.WIDTH(MAX_IMAGE_SAMPLE_LOG)) u_col (
      .clk, .rst, .en_i(acc & smp_t & line_t & band_t), .term_val_i(col_last), .term_o(col_t)
   );
   wrap_counter #(.WIDTH(MAX_IMAGE_LINE_LOG)) u_row (
      .clk, .rst, .en_i(acc & smp_t & line_t & band_t & col_t), .term_val_i(row_last), .term_o(row_t)
   );

   assign exp_f.last_s = smp_t;
   assign exp_f.last_r = smp_t & line_t;
   assign exp_f.last_b = smp_t & line_t & band_t;
   assign exp_f.last_i = smp_t & line_t & band_t & col_t & row_t;
   assign rcv_f        = '{bus.input_last_s, bus.input_last_r, bus.input_last_b, bus.input_last_i};
   assign mism         = acc & (rcv_f != exp_f);

   always_comb begin
      state_d = acc ? (exp_f.last_i ? IDLE : RUN) : state_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      cfg_bs_d = acc & first ? config_block_samples : cfg_bs_q;
      cfg_bl_d = acc & first ? config_block_lines   : cfg_bl_q;
      cfg_is_d = acc & first ? config_image_samples : cfg_is_q;
      cfg_il_d = acc & first ? config_image_lines   : cfg_il_q;
      cfg_nb_d = acc & first ? config_image_bands   : cfg_nb_q;
      ov_d     = in_rdy ? bus.input_valid : ov_q;
      od_d     = acc ? bus.input_data : od_q;
      ol_d     = acc ? exp_f.last_i : ol_q;
      ef_d     = ef_q | mism;
      ec_d     = mism && !(&ec_q) ? ec_q + ERR_COUNT_WIDTH'(1) : ec_q;
      done_d   = acc & exp_f.last_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_bs_q <= '0;
         cfg_bl_q <= '0;
         cfg_is_q <= '0;
         cfg_il_q <= '0;
         cfg_nb_q <= '0;
         rdy_q    <= 1'b0;
         ov_q     <= 1'b0;
         od_q     <= '0;
         ol_q     <= 1'b0;
         ef_q     <= 1'b0;
         ec_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         cfg_bs_q <= cfg_bs_d;
         cfg_bl_q <= cfg_bl_d;
         cfg_is_q <= cfg_is_d;
         cfg_il_q <= cfg_il_d;
         cfg_nb_q <= cfg_nb_d;
         rdy_q    <= 1'b1;
         ov_q     <= ov_d;
         od_q     <= od_d;
         ol_q     <= ol_d;
         ef_q     <= ef_d;
         ec_q     <= ec_d;
         done_q   <= done_d;
      end
   end

   assign bus.input_ready  = in_rdy;
   assign bus.output_valid = ov_q;
   assign bus.output_data  = od_q;
   assign bus.output_last  = ol_q;
   assign error_flag       = ef_q;
   assign error_count      = ec_q;
   assign image_done       = done_q;

endmodule
